// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM-style condition codes, flag bit positions and
// the condition evaluator used by both the fetch and the execute stages.
package cpu_pkg;

    // Condition field encodings (instruction bits [31:28])
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Bit positions of the flags inside the NZCV nibble
    localparam int NB = 3;
    localparam int ZB = 2;
    localparam int CB = 1;
    localparam int VB = 0;

    // Returns 1 when an instruction with condition `code` must execute under
    // the given flags. Code 4'hF is treated as always.
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic result;
        n = nzcv[NB];
        z = nzcv[ZB];
        c = nzcv[CB];
        v = nzcv[VB];
        result = 1'b1;
        case (code)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = z | (n != v);
            default: result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: circular buffer of {pc, instruction} entries with a
// combinational head so the condition field can be evaluated before popping.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW:0]      count_reg;

    // Pointer and occupancy tracking; clear empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Entry storage; no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);

    // The issue rule in the fetch unit reserves a slot for every read in flight
    push_never_full: assert property (@(posedge clk) disable iff (rst || clear) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction fetch stage: issues ROM reads ahead of demand,
// queues {pc, word} pairs and releases the head to IR when its condition holds.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                ROM_AW   = 6,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_ir,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [3:0]        NZCV,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       IR,
    output logic [ADDR_W-1:0] IR_pc,
    output logic              W_IR_valid,
    output logic              fetch_stall,
    output logic              q_empty,
    output logic              q_full
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = ADDR_W + 32;

    logic [ADDR_W-1:0] fpc_reg;
    logic              epoch_reg;
    logic              inflight_reg;
    logic              inflight_epoch_reg;
    logic [ADDR_W-1:0] issued_pc_reg;
    logic [31:0]       ir_reg;
    logic [ADDR_W-1:0] ir_pc_reg;

    logic [CW-1:0]     q_count;
    logic [QW-1:0]     q_head;
    logic [ADDR_W-1:0] head_pc;
    logic [31:0]       head_instr;
    logic [CW:0]       occupancy;
    logic              pop;
    logic              push;
    logic              issue;
    logic              unused_target_bits;

    assign head_pc    = q_head[QW-1:32];
    assign head_instr = q_head[31:0];

    // A redirect freezes the queue for its cycle; reset overrides everything
    assign pop  = write_ir & ~q_empty & ~redirect & ~rst;

    // Slots already committed: queued words plus the read still in flight,
    // less the one leaving this cycle
    assign occupancy = {1'b0, q_count} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);
    assign issue     = ~rst & ~redirect & (occupancy < (CW + 1)'(DEPTH));

    // Responses issued before the last redirect carry a stale epoch
    assign push = inflight_reg & (inflight_epoch_reg == epoch_reg) & ~redirect & ~rst;

    assign rom_en      = issue;
    assign rom_addr    = fpc_reg[ROM_AW+1:2];
    assign W_IR_valid  = pop & cond_eval(head_instr[31:28], NZCV);
    assign fetch_stall = write_ir & q_empty & ~redirect;
    assign IR          = ir_reg;
    assign IR_pc       = ir_pc_reg;

    // Byte-offset bits of the branch target carry no meaning
    assign unused_target_bits = ^redirect_pc[1:0];

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   ({issued_pc_reg, rom_data}),
        .head  (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    // Fetch pointer, epoch and in-flight read bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_reg            <= RESET_PC;
            epoch_reg          <= 1'b0;
            inflight_reg       <= 1'b0;
            inflight_epoch_reg <= 1'b0;
            issued_pc_reg      <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_epoch_reg <= epoch_reg;
                issued_pc_reg      <= fpc_reg;
            end
            if (redirect) begin
                fpc_reg   <= {redirect_pc[ADDR_W-1:2], 2'b00};
                epoch_reg <= ~epoch_reg;
            end else if (issue) begin
                fpc_reg <= fpc_reg + ADDR_W'(4);
            end
        end
    end

    // Instruction register loads only for popped words whose condition passes
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_reg    <= '0;
            ir_pc_reg <= '0;
        end else if (W_IR_valid) begin
            ir_reg    <= head_instr;
            ir_pc_reg <= head_pc;
        end
    end

endmodule
